irq_timer_bank: RTL and testbench

//  Multi-channel programmable interrupt timer; parametrised successor to the fixed single-period timer.
//  N_CH independent down-counters share one prescaler. Each has its own reload value, enable,

---
 rtl/irq_timer_bank_pkg.sv | 18 +
 rtl/irq_timer_bank_channel.sv | 75 +++++++
 rtl/irq_timer_bank.sv | 98 +++++++++
 tb/tb_irq_timer_bank.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/irq_timer_bank_pkg.sv
// Shared definitions for the interrupt timer bank: register map and CTRL bit layout.
package irq_timer_bank_pkg;

  // Per-channel register select, taken from addr[1:0]
  typedef enum logic [1:0] {
    REG_RELOAD = 2'd0,
    REG_CTRL   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_PEND   = 2'd3
  } reg_sel_e;

  // CTRL register layout
  localparam int CTRL_EN    = 0;
  localparam int CTRL_PER   = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_W     = 3;

endpackage

// File: rtl/irq_timer_bank_channel.sv
// One timer channel: reload/ctrl/count/pending registers and the expiry logic.
// The FSM state is the EN bit itself (IDLE when clear, RUN when set).
module irq_timer_bank_channel
  import irq_timer_bank_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              we_reload,
  input  logic              we_ctrl,
  input  logic              we_count,
  input  logic              we_pend,
  input  logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  reload,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CNT_W-1:0]  count,
  output logic              pend,
  output logic              irq
);

  logic [CNT_W-1:0]  reload_q, reload_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pend_q, pend_d;

  // Next-state: countdown/expiry first, then bus writes override (write wins),
  // except that an expiry always sets pending even against a w1c clear.
  always_comb begin
    reload_d = reload_q;
    ctrl_d   = ctrl_q;
    count_d  = count_q;
    pend_d   = pend_q;

    if (we_reload) reload_d = wdata[CNT_W-1:0];
    if (we_pend && wdata[0]) pend_d = 1'b0;

    if (ctrl_q[CTRL_EN] && tick && !we_count) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        pend_d = 1'b1;
        if (ctrl_q[CTRL_PER]) count_d = reload_q;
        else                  ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    if (we_ctrl)  ctrl_d  = wdata[CTRL_W-1:0];
    if (we_count) count_d = wdata[CNT_W-1:0];
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= '0;
      ctrl_q   <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign reload = reload_q;
  assign ctrl   = ctrl_q;
  assign count  = count_q;
  assign pend   = pend_q;
  assign irq    = pend_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: rtl/irq_timer_bank.sv
// Multi-channel programmable interrupt timer: shared prescaler, address decode,
// per-channel timers and a combinational read mux.
module irq_timer_bank
  import irq_timer_bank_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int CNT_W     = 16,
  parameter int DATA_W    = 16,
  parameter int PRESC_DIV = 8,
  parameter int ADDR_W    = $clog2(N_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [N_CH-1:0]   irq
);

  localparam int PW   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [CH_W-1:0] ch_sel;
  reg_sel_e        rsel;

  logic [CNT_W-1:0]  reload_a [N_CH];
  logic [CTRL_W-1:0] ctrl_a   [N_CH];
  logic [CNT_W-1:0]  count_a  [N_CH];
  logic              pend_a   [N_CH];

  // With PRESC_DIV = 1 the counter sits at 0 and tick is constantly high.
  assign tick = (presc_q == PW'(PRESC_DIV - 1));

  // Free-running prescaler, wraps at PRESC_DIV-1
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // A single-channel bank has no channel field in the address.
  if (ADDR_W > 2) begin : g_chsel
    assign ch_sel = addr[ADDR_W-1:2];
  end else begin : g_chsel0
    assign ch_sel = '0;
  end

  assign rsel = reg_sel_e'(addr[1:0]);

  // Channel indices at or beyond N_CH match no instance, so writes there are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = we && (ch_sel == CH_W'(i));

    irq_timer_bank_channel #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .we_reload (hit && (rsel == REG_RELOAD)),
      .we_ctrl   (hit && (rsel == REG_CTRL)),
      .we_count  (hit && (rsel == REG_COUNT)),
      .we_pend   (hit && (rsel == REG_PEND)),
      .wdata     (wdata),
      .reload    (reload_a[i]),
      .ctrl      (ctrl_a[i]),
      .count     (count_a[i]),
      .pend      (pend_a[i]),
      .irq       (irq[i])
    );
  end

  // Read mux; unmapped channels and unused bits read as zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (rsel)
          REG_RELOAD: rdata = DATA_W'(reload_a[i]);
          REG_CTRL:   rdata = DATA_W'(ctrl_a[i]);
          REG_COUNT:  rdata = DATA_W'(count_a[i]);
          REG_PEND:   rdata = DATA_W'(pend_a[i]);
          default:    rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_timer_bank.sv
// Directed bench for irq_timer_bank: 8-channel bank with PRESC_DIV=4, plus a
// 1-channel bank with PRESC_DIV=1 for the edge-parameter cases.
module tb_irq_timer_bank;
  localparam int N_CH = 8, DATA_W = 16, ADDR_W = 5, PDIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [N_CH-1:0]   irq;

  logic              reset1, we1;
  logic [1:0]        addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic [0:0]        irq1;

  int ntests = 0, nfail = 0;
  int ph = 0;
  int n, bad;
  logic [DATA_W-1:0] v;

  irq_timer_bank #(.N_CH(N_CH), .CNT_W(16), .DATA_W(DATA_W), .PRESC_DIV(PDIV)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq));

  irq_timer_bank #(.N_CH(1), .CNT_W(16), .DATA_W(DATA_W), .PRESC_DIV(1)) dut1 (
    .clk(clk), .reset(reset1), .we(we1), .addr(addr1), .wdata(wdata1), .rdata(rdata1), .irq(irq1));

  // Expected prescaler phase: the next edge is a tick edge when ph == PDIV-1
  always @(posedge clk) ph <= reset ? 0 : ((ph == PDIV - 1) ? 0 : ph + 1);

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input int d);
    addr = ADDR_W'(a); wdata = DATA_W'(d); we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input int a, output logic [DATA_W-1:0] val);
    addr = ADDR_W'(a); #1; val = rdata;
  endtask

  task automatic wr1(input int a, input int d);
    addr1 = 2'(a); wdata1 = DATA_W'(d); we1 = 1'b1;
    step();
    we1 = 1'b0;
  endtask

  task automatic rd1(input int a, output logic [DATA_W-1:0] val);
    addr1 = 2'(a); #1; val = rdata1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic align();
    while (ph != PDIV - 1) step();
  endtask

  task automatic wait_irq(input int idx, input int limit, output int cnt);
    cnt = 0;
    while (irq[idx] !== 1'b1 && cnt < limit) begin step(); cnt++; end
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1; we = 1'b0; we1 = 1'b0;
    addr = '0; addr1 = '0; wdata = '0; wdata1 = '0;

    // 1: reset state
    step(); step();
    check("rst_irq", 32'(irq), 0);
    check("rst_irq1", 32'(irq1), 0);
    for (int a = 0; a < 32; a++) begin
      rd(a, v);
      check($sformatf("rst_rdata_%0d", a), 32'(v), 0);
    end
    for (int a = 0; a < 4; a++) begin
      rd1(a, v);
      check($sformatf("rst_rdata1_%0d", a), 32'(v), 0);
    end
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin step(); if (irq !== '0) bad++; end
    check("idle_irq_100", 32'(bad), 0);

    // 2: periodic ch0, RELOAD=3 -> 16-cycle period
    do_reset();
    wr(0, 3); wr(2, 3); align(); wr(1, 7);
    wait_irq(0, 40, n);
    check("per_first_rise", 32'(n), 16);
    rd(2, v); check("per_count_reloaded", 32'(v), 3);
    rd(3, v); check("per_pend_read", 32'(v), 1);
    wr(3, 1);
    check("per_irq_cleared", 32'(irq[0]), 0);
    wait_irq(0, 40, n);
    check("per_second_rise", 32'(n + 1), 16);
    wr(3, 1);
    wait_irq(0, 40, n);
    check("per_third_rise", 32'(n + 1), 16);

    // 3: one-shot ch2, COUNT=2 -> expires after 3 ticks
    do_reset();
    wr(10, 2); align(); wr(9, 5);
    wait_irq(2, 40, n);
    check("os_rise", 32'(n), 12);
    rd(9, v);  check("os_ctrl", 32'(v), 4);
    rd(10, v); check("os_count", 32'(v), 0);
    rd(11, v); check("os_pend", 32'(v), 1);
    wr(11, 1);
    bad = 0;
    for (int c = 0; c < 200; c++) begin step(); if (irq !== '0) bad++; end
    check("os_no_more_irq", 32'(bad), 0);

    // 4: ch1 periodic RELOAD=1 (8 cycles), ch5 periodic RELOAD=2 but masked
    do_reset();
    wr(4, 1); wr(6, 1); wr(20, 2); wr(22, 2); wr(21, 3);
    align(); wr(5, 7);
    wait_irq(1, 40, n);
    check("mc_ch1_rise", 32'(n), 8);
    wr(7, 1);
    check("mc_ch1_cleared", 32'(irq[1]), 0);
    wait_irq(1, 40, n);
    check("mc_ch1_period", 32'(n + 1), 8);
    rd(23, v); check("mc_ch5_pend", 32'(v), 1);
    check("mc_ch5_masked", 32'(irq[5]), 0);
    wr(21, 7);
    check("mc_ch5_unmasked", 32'(irq[5]), 1);

    // 5: collisions
    do_reset();
    wr(0, 3); wr(2, 3); align(); wr(1, 7);
    wait_irq(0, 40, n);
    check("col_first_rise", 32'(n), 16);
    wr(3, 1);
    check("col_cleared", 32'(irq[0]), 0);
    repeat (14) step();
    wr(3, 1);
    check("col_w1c_vs_expiry_irq", 32'(irq[0]), 1);
    rd(3, v); check("col_w1c_vs_expiry_pend", 32'(v), 1);
    align(); wr(2, 7);
    rd(2, v); check("col_count_write_wins", 32'(v), 7);
    align(); step();
    rd(2, v); check("col_count_next_tick", 32'(v), 6);
    align(); wr(13, 7);
    repeat (3) step();
    wr(13, 4);
    rd(13, v); check("col_ctrl_write_wins", 32'(v), 4);
    rd(15, v); check("col_ctrl_pend_set", 32'(v), 1);
    check("col_ctrl_irq", 32'(irq[3]), 1);

    // 6: N_CH=1, PRESC_DIV=1, RELOAD=0 periodic; then reset mid-count
    reset1 = 1'b0;
    wr1(0, 0); wr1(1, 7);
    check("e1_irq_at_enable", 32'(irq1), 0);
    step();
    check("e1_irq_first", 32'(irq1), 1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin wr1(3, 1); if (irq1 !== 1'b1) bad++; end
    check("e1_pend_every_cycle", 32'(bad), 0);
    rd1(3, v); check("e1_pend_read", 32'(v), 1);
    wr1(0, 100); wr1(2, 50);
    repeat (5) step();
    rd1(2, v); check("e1_count_midway", 32'(v), 45);
    check("e1_irq_before_reset", 32'(irq1), 1);
    reset1 = 1'b1; step();
    rd1(2, v); check("e1_reset_count", 32'(v), 0);
    check("e1_reset_irq", 32'(irq1), 0);
    rd1(1, v); check("e1_reset_ctrl", 32'(v), 0);
    reset1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
